// File: rtl/bcd_cikarici_seri.sv
// bcd_cikarici_seri: digit-serial packed-BCD subtractor.
// Produces |a - b| one BCD digit per clock, least significant digit first,
// plus a sign flag and an invalid-operand flag, behind a start/busy/done handshake.
// A negative raw difference leaves the ten's complement in the working register.
// A second serial pass then negates that register (0 - working) to recover the magnitude.

module bcd_cikarici_seri #(
  parameter int BASAMAK = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*BASAMAK-1:0]   a,
  input  logic [4*BASAMAK-1:0]   b,
  output logic [4*BASAMAK-1:0]   fark,
  output logic                   negatif,
  output logic                   hata,
  output logic                   busy,
  output logic                   done
);

  localparam int W  = 4 * BASAMAK;
  localparam int IW = (BASAMAK > 1) ? $clog2(BASAMAK) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CIKAR = 2'd1,
    TUMLE = 2'd2,
    BITTI = 2'd3
  } state_t;

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [W-1:0]    work_reg;
  logic            borrow;
  logic [IW-1:0]   k;

  logic [3:0]      min_digit;
  logic [3:0]      sub_digit;
  logic [4:0]      diff_wide;
  logic [3:0]      digit_res;
  logic            borrow_next;
  logic [W-1:0]    work_next;
  logic            last_digit;
  logic            operand_bad;

  // True when any 4-bit digit of the packed value lies outside 0..9.
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < BASAMAK; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end
    end
    return bad;
  endfunction

  assign operand_bad = has_bad_digit(a) | has_bad_digit(b);
  assign last_digit  = (k == IW'(BASAMAK - 1));

  // One digit step: the minuend is a_k in CIKAR and 0 in TUMLE.
  // The subtrahend is b_k in CIKAR and the working digit in TUMLE.
  always_comb begin
    min_digit = 4'd0;
    sub_digit = 4'd0;
    if (state == CIKAR) begin
      min_digit = a_reg[k*4 +: 4];
      sub_digit = b_reg[k*4 +: 4];
    end else begin
      min_digit = 4'd0;
      sub_digit = work_reg[k*4 +: 4];
    end
    diff_wide   = {1'b0, min_digit} - {1'b0, sub_digit} - {4'd0, borrow};
    borrow_next = diff_wide[4];
    digit_res   = diff_wide[4] ? (diff_wide[3:0] + 4'd10) : diff_wide[3:0];
    work_next   = work_reg;
    work_next[k*4 +: 4] = digit_res;
  end

  // Control FSM with registered result, flag and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      work_reg <= '0;
      borrow   <= 1'b0;
      k        <= '0;
      fark     <= '0;
      negatif  <= 1'b0;
      hata     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (operand_bad) begin
              fark    <= '0;
              negatif <= 1'b0;
              hata    <= 1'b1;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= BITTI;
            end else begin
              a_reg    <= a;
              b_reg    <= b;
              work_reg <= '0;
              borrow   <= 1'b0;
              k        <= '0;
              busy     <= 1'b1;
              state    <= CIKAR;
            end
          end
        end

        CIKAR: begin
          work_reg <= work_next;
          if (last_digit) begin
            k      <= '0;
            borrow <= 1'b0;
            if (!borrow_next) begin
              fark    <= work_next;
              negatif <= 1'b0;
              hata    <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= BITTI;
            end else begin
              state <= TUMLE;
            end
          end else begin
            borrow <= borrow_next;
            k      <= k + IW'(1);
          end
        end

        TUMLE: begin
          work_reg <= work_next;
          if (last_digit) begin
            k       <= '0;
            borrow  <= 1'b0;
            fark    <= work_next;
            negatif <= 1'b1;
            hata    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= BITTI;
          end else begin
            borrow <= borrow_next;
            k      <= k + IW'(1);
          end
        end

        BITTI: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_cikarici_seri.sv
// tb_bcd_cikarici_seri: self-checking bench for the serial BCD subtractor.
// Expected results come from an integer model: decode BCD, subtract, re-encode.

module tb_bcd_cikarici_seri;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] fark;
  logic         negatif;
  logic         hata;
  logic         busy;
  logic         done;

  int assert_count;
  int fail_count;

  logic [W-1:0] prev_fark;
  logic         prev_neg;
  logic         prev_hata;

  bcd_cikarici_seri #(.BASAMAK(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .fark    (fark),
    .negatif (negatif),
    .hata    (hata),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model helpers
  function automatic bit bcd_valid(input logic [W-1:0] v);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int i = N - 1; i >= 0; i--) begin
      r = r * 10 + int'(v[4*i +: 4]);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r;
    int x;
    x = v;
    r = '0;
    for (int i = 0; i < N; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one start pulse and checks latency, busy length, result and hold behaviour.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input bit mid_change);
    int ia;
    int ib;
    int lat_exp;
    int j;
    int busy_cycles;
    logic [W-1:0] exp_fark;
    logic exp_neg;
    logic exp_hata;

    if (!bcd_valid(av) || !bcd_valid(bv)) begin
      exp_fark = '0;
      exp_neg  = 1'b0;
      exp_hata = 1'b1;
      lat_exp  = 0;
    end else begin
      ia = bcd_to_int(av);
      ib = bcd_to_int(bv);
      exp_neg  = (ia < ib);
      exp_fark = int_to_bcd(exp_neg ? (ib - ia) : (ia - ib));
      exp_hata = 1'b0;
      lat_exp  = exp_neg ? 2 * N : N;
    end

    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (mid_change) begin
      a = W'($urandom);
      b = W'($urandom);
    end

    if (lat_exp > 0) begin
      checkOutput("hold_fark", 32'(fark), 32'(prev_fark));
      checkOutput("hold_negatif", 32'(negatif), 32'(prev_neg));
      checkOutput("hold_hata", 32'(hata), 32'(prev_hata));
    end

    j = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && j < 4 * N + 10) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      j++;
    end

    checkOutput("latency", 32'(j), 32'(lat_exp));
    checkOutput("busy_cycles", 32'(busy_cycles), 32'(lat_exp));
    checkOutput("fark", 32'(fark), 32'(exp_fark));
    checkOutput("negatif", 32'(negatif), 32'(exp_neg));
    checkOutput("hata", 32'(hata), 32'(exp_hata));
    checkOutput("busy_at_done", 32'(busy), 32'(0));

    prev_fark = exp_fark;
    prev_neg  = exp_neg;
    prev_hata = exp_hata;

    @(negedge clk);
    checkOutput("done_single", 32'(done), 32'(0));
    checkOutput("fark_held", 32'(fark), 32'(exp_fark));
  endtask

  initial begin
    int j;
    int seen_done;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    assert_count = 0;
    fail_count   = 0;
    prev_fark    = '0;
    prev_neg     = 1'b0;
    prev_hata    = 1'b0;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_fark", 32'(fark), 32'(0));
    checkOutput("rst_negatif", 32'(negatif), 32'(0));
    checkOutput("rst_hata", 32'(hata), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed operations");
    applyStimulus(16'h0042, 16'h0017, 1'b0);
    applyStimulus(16'h0017, 16'h0042, 1'b0);
    applyStimulus(16'h1000, 16'h0001, 1'b0);
    applyStimulus(16'h0000, 16'h9999, 1'b0);
    applyStimulus(16'h5555, 16'h5555, 1'b0);
    applyStimulus(16'h00A3, 16'h0001, 1'b0);
    applyStimulus(16'h0042, 16'h0017, 1'b0);
    applyStimulus(16'h0300, 16'h0F00, 1'b0);
    applyStimulus(16'h0123, 16'h0456, 1'b1);
    applyStimulus(16'h9999, 16'h0000, 1'b1);

    $display("[TB] start held high");
    @(negedge clk);
    a = 16'h0042;
    b = 16'h0017;
    start = 1'b1;
    j = 0;
    while (done !== 1'b1 && j < 30) begin
      @(negedge clk);
      j++;
    end
    checkOutput("held_first_done", 32'(done), 32'(1));
    checkOutput("held_fark", 32'(fark), 32'h0025);
    j = 0;
    seen_done = 0;
    do begin
      @(negedge clk);
      j++;
      if (j == 1) begin
        checkOutput("held_no_back_to_back", 32'(done), 32'(0));
        checkOutput("held_idle_gap", 32'(busy), 32'(0));
      end
      if (j == 2) checkOutput("held_accept_after_idle", 32'(busy), 32'(1));
      if (done === 1'b1) seen_done = 1;
    end while (seen_done == 0 && j < 30);
    checkOutput("held_period", 32'(j), 32'(N + 2));
    checkOutput("held_fark2", 32'(fark), 32'h0025);
    start = 1'b0;
    @(negedge clk);
    checkOutput("held_done_drop", 32'(done), 32'(0));
    prev_fark = 16'h0025;
    prev_neg  = 1'b0;
    prev_hata = 1'b0;

    $display("[TB] randomized operations");
    for (int n = 0; n < 24; n++) begin
      for (int d = 0; d < N; d++) begin
        ra[4*d +: 4] = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        rb[4*d +: 4] = ($urandom_range(0, 39) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      if (n % 8 == 3) rb = ra;
      applyStimulus(ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("[TB] reset during operation");
    applyStimulus(16'h0017, 16'h0042, 1'b0);
    @(negedge clk);
    a = 16'h0042;
    b = 16'h0017;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", 32'(busy), 32'(0));
    checkOutput("midrst_done", 32'(done), 32'(0));
    checkOutput("midrst_fark", 32'(fark), 32'(0));
    checkOutput("midrst_negatif", 32'(negatif), 32'(0));
    checkOutput("midrst_hata", 32'(hata), 32'(0));
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1;
    end
    checkOutput("midrst_no_done", 32'(seen_done), 32'(0));
    prev_fark = '0;
    prev_neg  = 1'b0;
    prev_hata = 1'b0;
    applyStimulus(16'h0009, 16'h0010, 1'b0);

    $display("[TB] reset wins over start");
    @(negedge clk);
    a = 16'h0042;
    b = 16'h0017;
    start = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    checkOutput("rst_priority_busy", 32'(busy), 32'(0));
    checkOutput("rst_priority_fark", 32'(fark), 32'(0));
    @(negedge clk);
    checkOutput("rst_priority_done", 32'(done), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/bcd_cikarici_seri.md
Name: bcd_cikarici_seri

Overview:
- Digit-serial multi-digit packed-BCD subtractor; computes |A − B| and a sign flag, one BCD digit per clock, LSD first.
- Inverse arithmetic partner to the team's BCD adder chain: the decrement/difference path of the same BCD datapath.
- Start/busy/done handshake toward the controlling FSM.
- Rejects non-BCD operand digits.

Parameters:
- BASAMAK, 4, number of BCD digits per operand (≥1); operand width = 4*BASAMAK.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  4*BASAMAK  minuend, packed BCD, digit k at bits [4k+3:4k]
- b  input  4*BASAMAK  subtrahend, same packing
- fark  output  4*BASAMAK  registered magnitude |A−B|, packed BCD
- negatif  output  1  registered; 1 when A<B
- hata  output  1  registered; 1 when any digit of a or b was >9 at start
- busy  output  1  high while computing
- done  output  1  single-cycle completion pulse

Behaviour:
- Reset (rst=1 at clk edge, any state including mid-operation): state=IDLE. fark=0, negatif=0, hata=0, busy=0, done=0. Internal operand, working and borrow registers are cleared.
- States: IDLE, CIKAR, TUMLE, BITTI.
- IDLE, start=0:
  - Stay in IDLE.
  - Outputs hold their last values.
- IDLE, start=1, all digits valid:
  - Latch a and b.
  - Clear borrow; set digit index k=0.
  - Go to CIKAR.
- IDLE, start=1, any digit of a or b >9:
  - Go to BITTI with pending result fark=0, negatif=0, hata=1.
- CIKAR (one cycle per digit k = 0..BASAMAK−1):
  - d = a_k − b_k − borrow, computed 5 bits signed.
  - If d<0: digit = d+10, borrow=1. Else: digit = d, borrow=0.
  - Store the digit into working register slot k.
  - After k = BASAMAK−1:
    - If final borrow=0: go to BITTI with negatif=0.
    - Otherwise: clear borrow, set k=0, go to TUMLE.
- TUMLE (one cycle per digit):
  - Working register holds the ten's complement of the true result. Replace it by 0 − working, using the same per-digit borrow rule with minuend digits 0.
  - After the last digit: go to BITTI with negatif=1.
- BITTI (exactly one cycle):
  - done=1.
  - fark, negatif and hata are loaded at entry. They are valid in this cycle and held until the next accepted start.
  - hata=0 on any valid operation.
  - Next state: IDLE unconditionally. start is ignored here.
- busy=1 exactly in CIKAR and TUMLE; 0 in IDLE and BITTI.
- Outputs fark, negatif and hata are not modified during CIKAR/TUMLE; they keep the previous result.
- Latency from the clk edge that samples start (edge t) to the first cycle with done=1:
  - t+BASAMAK+1 when A≥B
  - t+2*BASAMAK+1 when A<B
  - t+1 for an invalid operand
- start asserted while busy or in BITTI is ignored; it is not queued.
- Equal operands give fark=0, negatif=0; zero is never reported negative.
- a and b may change after start is sampled without affecting the result.
- rst has priority over start when both are high at the same edge.

Test Plan (BASAMAK=4):
- a=0042, b=0017, start pulse → busy high 4 cycles; done high exactly at t+5; fark=0025, negatif=0, hata=0.
- a=0017, b=0042 → busy high 8 cycles; done at t+9; fark=0025, negatif=1.
- Borrow chain: a=1000, b=0001 → fark=0999, negatif=0. Then a=0000, b=9999 → fark=9999, negatif=1. Then a=5555, b=5555 → fark=0000, negatif=0.
- Invalid digit: a=00A3, b=0001 → done at t+1 with hata=1, fark=0000, negatif=0, busy never high. The next valid run clears hata.
- Handshake:
  - Hold start high continuously with a=0042, b=0017. Exactly one operation per IDLE visit; done pulses are never back-to-back. A new operation is accepted only in the cycle after BITTI.
  - Change a/b mid-run → the result still reflects the latched values.
- Reset mid-operation: assert rst during the 2nd CIKAR cycle → next cycle state IDLE, busy=0, done=0, fark=0, negatif=0, hata=0, and no done pulse follows. A subsequent start with a=0009, b=0010 → fark=0001, negatif=1.
